// File: rtl/bin2seg_seq.sv
// Sequential binary-to-7-segment converter using iterative double dabble.
// Optional leading-zero blanking is enabled by defining BIN2SEG_LZ_BLANK_EN.
module bin2seg_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    din,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [7*DIGITS-1:0] seg
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SEG_W = 7 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  function automatic logic [63:0] pow10_m1(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10_m1(DIGITS);

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_next_q, ovf_next_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [SEG_W-1:0]   seg_q, seg_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;
  logic [SEG_W-1:0]   seg_dec;
  logic               seen;

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    bcd_shift = BCD_W'({bcd_adj, bin_q[WIDTH-1]});
  end

  // Glyph decode of the final BCD value, scanning from the most significant digit.
  always_comb begin
    seg_dec = '0;
    seen    = 1'b0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
`ifdef BIN2SEG_LZ_BLANK_EN
      if ((bcd_shift[4*k +: 4] != 4'd0) || (k == 0)) begin
        seen = 1'b1;
      end
      seg_dec[7*k +: 7] = seen ? glyph(bcd_shift[4*k +: 4]) : 7'h00;
`else
      seen              = 1'b1;
      seg_dec[7*k +: 7] = glyph(bcd_shift[4*k +: 4]);
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_next_d = ovf_next_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    seg_d      = seg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d      = din;
          bcd_d      = '0;
          cnt_d      = CNT_W'(WIDTH);
          ovf_next_d = (64'(din) > MAX_VAL);
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_shift;
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        // Last step: results land in the LOAD cycle together with done.
        if (cnt_q == CNT_W'(1)) begin
          state_d = LOAD;
          done_d  = 1'b1;
          ovf_d   = ovf_next_q;
          seg_d   = ovf_next_q ? {DIGITS{7'h40}} : seg_dec;
        end
      end
      LOAD: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      seg_q      <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_next_q <= ovf_next_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      seg_q      <= seg_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_bin2seg_seq.sv
// Scoreboard bench for bin2seg_seq: three configurations (8/3, 8/2, 16/5)
// checked every cycle for busy, done timing, and held or updated seg/ovf.
module tb_bin2seg_seq;

`ifdef BIN2SEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b, start_c;
  logic [31:0] din_w;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic        busy_c, done_c, ovf_c;
  logic [20:0] seg_a;
  logic [13:0] seg_b;
  logic [34:0] seg_c;

  bin2seg_seq #(.WIDTH(8), .DIGITS(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .din(din_w[7:0]),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .seg(seg_a)
  );

  bin2seg_seq #(.WIDTH(8), .DIGITS(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .din(din_w[7:0]),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .seg(seg_b)
  );

  bin2seg_seq #(.WIDTH(16), .DIGITS(5)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .din(din_w[15:0]),
    .busy(busy_c), .done(done_c), .ovf(ovf_c), .seg(seg_c)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    int          t0;
    int          due;
    logic [55:0] seg;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  logic [55:0] held_seg [3];
  logic        held_ovf [3];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int wof(input int id);
    return (id == 2) ? 16 : 8;
  endfunction

  function automatic int dof(input int id);
    return (id == 0) ? 3 : ((id == 1) ? 2 : 5);
  endfunction

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Reference: decimal digits by division, returns {ovf, seg}.
  function automatic logic [56:0] model(input longint v, input int digits);
    longint      lim = 1;
    longint      r;
    logic [55:0] s = '0;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    if (v >= lim) begin
      for (int i = 0; i < digits; i++) s[7*i +: 7] = 7'h40;
      return {1'b1, s};
    end
    r = v;
    for (int i = 0; i < digits; i++) begin
      if (i == 0 || r != 0 || !LZ) s[7*i +: 7] = glyph(int'(r % 10));
      r = r / 10;
    end
    return {1'b0, s};
  endfunction

  task automatic monitor_one(input int id, input logic dn, input logic bz,
                             input logic [55:0] s, input logic o);
    logic act;
    logic due_now;
    exp_t e;
    if (!rst_n) begin
      check($sformatf("rst_busy%0d", id), 64'(bz), 64'(0));
      check($sformatf("rst_done%0d", id), 64'(dn), 64'(0));
      check($sformatf("rst_ovf%0d", id), 64'(o), 64'(0));
      check($sformatf("rst_seg%0d", id), 64'(s), 64'(0));
      held_seg[id] = '0;
      held_ovf[id] = 1'b0;
      return;
    end
    act     = 1'b0;
    due_now = 1'b0;
    if (sb.size() > 0) begin
      if (sb[0].id == id && cyc >= sb[0].t0) act = 1'b1;
      if (sb[0].id == id && cyc == sb[0].due) due_now = 1'b1;
    end
    check($sformatf("busy%0d", id), 64'(bz), 64'(act));
    check($sformatf("done%0d", id), 64'(dn), 64'(due_now));
    if (dn && due_now) begin
      e = sb.pop_front();
      check($sformatf("seg%0d", id), 64'(s), 64'(e.seg));
      check($sformatf("ovf%0d", id), 64'(o), 64'(e.ovf));
      held_seg[id] = e.seg;
      held_ovf[id] = e.ovf;
    end else begin
      check($sformatf("hold_seg%0d", id), 64'(s), 64'(held_seg[id]));
      check($sformatf("hold_ovf%0d", id), 64'(o), 64'(held_ovf[id]));
    end
  endtask

  // Sample all DUTs mid-cycle, then advance past the next rising edge.
  task automatic tick();
    @(negedge clk);
    monitor_one(0, done_a, busy_a, 56'(seg_a), ovf_a);
    monitor_one(1, done_b, busy_b, 56'(seg_b), ovf_b);
    monitor_one(2, done_c, busy_c, 56'(seg_c), ovf_c);
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input logic [31:0] v);
    logic [56:0] m;
    exp_t        e;
    m     = model(longint'(v), dof(id));
    e.id  = id;
    e.t0  = cyc;
    e.due = cyc + wof(id);
    e.seg = m[55:0];
    e.ovf = m[56];
    sb.push_back(e);
  endtask

  task automatic start_conv(input int id, input logic [31:0] v);
    din_w   = v;
    start_a = (id == 0);
    start_b = (id == 1);
    start_c = (id == 2);
    tick();
    push(id, v);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic run(input int id, input logic [31:0] v);
    start_conv(id, v);
    repeat (wof(id) + 2) tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    din_w   = '0;
    for (int i = 0; i < 3; i++) begin
      held_seg[i] = '0;
      held_ovf[i] = 1'b0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    run(0, 123);

    // Asynchronous reset while idle, with no clock edge in between.
    rst_n = 1'b0;
    #2;
    check("async_seg", 64'(seg_a), 64'(0));
    check("async_busy", 64'(busy_a), 64'(0));
    check("async_done", 64'(done_a), 64'(0));
    check("async_ovf", 64'(ovf_a), 64'(0));
    for (int i = 0; i < 3; i++) begin
      held_seg[i] = '0;
      held_ovf[i] = 1'b0;
    end
    rst_n = 1'b1;
    tick();

    run(1, 100);
    run(1, 99);
    run(1, 255);
    run(2, 65535);
    run(2, 0);
    run(0, 0);
    run(0, 255);
    for (int i = 0; i < 4; i++) run(0, $urandom_range(0, 255));

    // Second start while busy must be ignored.
    start_conv(0, 45);
    repeat (3) tick();
    din_w   = 200;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (7) tick();

    // start held high: next conversion accepted in the IDLE cycle after LOAD.
    din_w   = 12345;
    start_c = 1'b1;
    tick();
    push(2, 12345);
    din_w = 7;
    repeat (17) tick();
    tick();
    push(2, 7);
    start_c = 1'b0;
    repeat (18) tick();

    // Reset mid-conversion aborts with no done pulse.
    start_conv(0, 77);
    repeat (4) tick();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    run(0, 7);

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
